vol_recording_ctrl_pio: RTL



---
 rtl/vol_recording_ctrl_pio.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vol_recording_ctrl_pio.sv
// -----------------------------------------------------------------------------
// vol_recording_ctrl_pio
//
// Avalon-MM slave (write/output direction) for volume-recording control.
// Gives the host CPU:
//   - a level control register driving out_port,
//   - self-timed trigger pulses of PULSE_CYCLES clocks on pulse_port,
//   - a sticky rising-edge capture of done_in (write-1-to-clear).
//
// Optional feature macro: VOL_RECORDING_CTRL_IRQ_EN
//   When defined, adds the IRQ_MASK register (address 3) and the registered
//   irq output (irq = |(DONE & mask)). When undefined, address 3 reads 0,
//   writes to it are dropped and the irq port does not exist.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register select (0 DATA, 1 PULSE, 2 DONE, 3 IRQ_MASK)
//   chipselect  slave select (qualifies writes only)
//   write_n     active-low write strobe
//   writedata   write data (only the low WIDTH bits are used)
//   readdata    registered read data, one cycle after address
//   out_port    level control outputs
//   pulse_port  trigger pulses to acquisition logic
//   done_in     recording-done inputs (already synchronous to clk)
//   irq         interrupt (only with VOL_RECORDING_CTRL_IRQ_EN)
// -----------------------------------------------------------------------------
module vol_recording_ctrl_pio #(
  parameter int WIDTH        = 4,
  parameter int PULSE_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pulse_port,
  input  logic [WIDTH-1:0] done_in
`ifdef VOL_RECORDING_CTRL_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] LP_PULSE_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] LP_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LP_CNT_ZERO   = {CNT_W{1'b0}};

  logic             w_wr;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] w_pulse_set;
  logic [WIDTH-1:0] w_done_clr;
  logic [WIDTH-1:0] w_done_edge;
  logic [WIDTH-1:0] w_rd_sel;
  logic             w_unused_bits;

  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pulse;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_done;
  logic [WIDTH-1:0] r_done_d;
`ifdef VOL_RECORDING_CTRL_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic             r_irq;
`endif

  assign w_wr          = chipselect & ~write_n;
  assign w_wr_data     = writedata[WIDTH-1:0];
  assign w_unused_bits = &{1'b0, writedata[31:WIDTH]};
  assign w_done_edge   = done_in & ~r_done_d;

  // Decode write strobes into per-channel pulse launches and DONE clears
  always_comb begin
    w_pulse_set = {WIDTH{1'b0}};
    w_done_clr  = {WIDTH{1'b0}};
    if (w_wr) begin
      case (address)
        2'd1:    w_pulse_set = w_wr_data;
        2'd2:    w_done_clr  = w_wr_data;
        default: begin
          w_pulse_set = {WIDTH{1'b0}};
          w_done_clr  = {WIDTH{1'b0}};
        end
      endcase
    end else begin
      w_pulse_set = {WIDTH{1'b0}};
      w_done_clr  = {WIDTH{1'b0}};
    end
  end

  // Read mux; busy is the registered pulse state, which equals (cnt != 0)
  always_comb begin
    w_rd_sel = {WIDTH{1'b0}};
    case (address)
      2'd0:    w_rd_sel = r_data;
      2'd1:    w_rd_sel = r_pulse;
      2'd2:    w_rd_sel = r_done;
`ifdef VOL_RECORDING_CTRL_IRQ_EN
      2'd3:    w_rd_sel = r_mask;
`else
      2'd3:    w_rd_sel = {WIDTH{1'b0}};
`endif
      default: w_rd_sel = {WIDTH{1'b0}};
    endcase
  end

  // Registered read data, refreshed every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= {{(32-WIDTH){1'b0}}, w_rd_sel};
    end
  end

  // DATA register driving the level outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= {WIDTH{1'b0}};
    end else if (w_wr && (address == 2'd0)) begin
      r_data <= w_wr_data;
    end else begin
      r_data <= r_data;
    end
  end

  // Per-channel pulse timers; a reload while busy extends the pulse seamlessly.
  // The pulse bit is computed from the pre-decrement count so it drops in the
  // same cycle the counter reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= LP_CNT_ZERO;
      end
      r_pulse <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_pulse_set[i]) begin
          r_cnt[i]   <= LP_PULSE_LOAD;
          r_pulse[i] <= 1'b1;
        end else if (r_cnt[i] != LP_CNT_ZERO) begin
          r_cnt[i]   <= r_cnt[i] - LP_CNT_ONE;
          r_pulse[i] <= (r_cnt[i] != LP_CNT_ONE);
        end else begin
          r_cnt[i]   <= LP_CNT_ZERO;
          r_pulse[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky done capture: new edges win over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done_d <= {WIDTH{1'b0}};
      r_done   <= {WIDTH{1'b0}};
    end else begin
      r_done_d <= done_in;
      r_done   <= (r_done & ~w_done_clr) | w_done_edge;
    end
  end

`ifdef VOL_RECORDING_CTRL_IRQ_EN
  // Interrupt mask register and registered interrupt (lags DONE by one cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= {WIDTH{1'b0}};
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd3)) begin
        r_mask <= w_wr_data;
      end else begin
        r_mask <= r_mask;
      end
      r_irq <= |(r_done & r_mask);
    end
  end

  assign irq = r_irq;
`endif

  assign readdata   = r_readdata;
  assign out_port   = r_data;
  assign pulse_port = r_pulse;

endmodule
